// File: rtl/fwd_pkg.sv
// Shared types and width helpers for the packet-memory AXI-Stream forwarder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fwd_pkg;

   // Forwarder control states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2,
      ST_HOLD   = 2'd3
   } fwd_state_t;

   // Number of read credits: words buffered plus words in flight
   localparam int FWD_CREDITS = 2;

   // Length counters must hold the full word count 2**addr_width, one bit wider than the address
   function automatic int fwd_plen_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fwd_fifo2.sv
// Two-entry synchronous FIFO; the head word sits in a register that drives the output directly.
// Latency: a push into an empty FIFO is visible at the head the next cycle.
// Backpressure: push ignored when full unless a pop frees a slot the same cycle; pop ignored when empty.
module fwd_fifo2 #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [1:0]            occ,
   output logic                  not_empty
);

   logic [DATA_WIDTH-1:0] tail;
   logic                  do_pop;
   logic                  do_push;

   assign not_empty = (occ != 2'd0);
   assign do_pop    = pop && not_empty;
   assign do_push   = push && ((occ != 2'd2) || do_pop);

   // Shift storage and track occupancy; head always holds the oldest word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (occ == 2'd0) head <= din;
               else             tail <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  head <= tail;
                  tail <= din;
               end else begin
                  head <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/axistream_forwarder.sv
// Drains an accepted packet from packet memory as an AXI-Stream master, one word per beat, then releases the buffer.
// Latency: first rd_en 1 cycle after ready is sampled, first tvalid 3 cycles after; done 1 cycle after the last beat.
// Backpressure: tready low stalls reads via 2 credits (buffered + in flight); reads resume the cycle tready returns.
module axistream_forwarder
   import fwd_pkg::*;
#(
   parameter int SNOOP_FWD_ADDR_WIDTH = 9,
   parameter int DATA_WIDTH           = 64,
   parameter int PLEN_WIDTH           = fwd_plen_width(SNOOP_FWD_ADDR_WIDTH)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ready_for_forwarder,
   input  logic [PLEN_WIDTH-1:0]           len_to_forwarder,
   output logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr,
   output logic                            forwarder_rd_en,
   input  logic [DATA_WIDTH-1:0]           forwarder_rd_data,
   output logic                            forwarder_done,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tvalid,
   output logic                            m_axis_tlast,
   input  logic                            m_axis_tready
);

   localparam logic [PLEN_WIDTH-1:0] PLEN_ONE = PLEN_WIDTH'(1);
   localparam logic [2:0]            CREDITS  = 3'(FWD_CREDITS);

   fwd_state_t            state;
   logic [PLEN_WIDTH-1:0] plen;
   logic [PLEN_WIDTH-1:0] rd_idx;
   logic [PLEN_WIDTH-1:0] out_idx;
   logic                  inflight;
   logic [1:0]            occ;
   logic                  fifo_vld;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  pop;
   logic                  issue;
   logic [2:0]            credit_used;

   // A pop frees its slot in the same cycle, which is what keeps full throughput with only 2 credits
   assign pop         = fifo_vld && m_axis_tready;
   assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign issue       = (state == ST_STREAM) && (rd_idx < plen) && (credit_used < CREDITS);

   // Address is the low bits of the index, so a max-length packet wraps the address but not the count
   assign forwarder_rd_en   = issue;
   assign forwarder_rd_addr = rd_idx[SNOOP_FWD_ADDR_WIDTH-1:0];

   assign m_axis_tvalid = fifo_vld;
   assign m_axis_tdata  = fifo_head;
   assign m_axis_tlast  = fifo_vld && (out_idx == (plen - PLEN_ONE));

   // Read data lands one cycle after rd_en and is pushed straight into the skid FIFO
   fwd_fifo2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .din       (forwarder_rd_data),
      .pop       (pop),
      .head      (fifo_head),
      .occ       (occ),
      .not_empty (fifo_vld)
   );

   // Control FSM with read/output index counters and the registered done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         plen           <= '0;
         rd_idx         <= '0;
         out_idx        <= '0;
         inflight       <= 1'b0;
         forwarder_done <= 1'b0;
      end else begin
         inflight       <= issue;
         forwarder_done <= 1'b0;
         if (issue) rd_idx  <= rd_idx + PLEN_ONE;
         if (pop)   out_idx <= out_idx + PLEN_ONE;
         case (state)
            ST_IDLE: begin
               if (ready_for_forwarder) begin
                  plen    <= len_to_forwarder;
                  rd_idx  <= '0;
                  out_idx <= '0;
                  if (len_to_forwarder == '0) begin
                     state          <= ST_DONE;
                     forwarder_done <= 1'b1;
                  end else begin
                     state <= ST_STREAM;
                  end
               end
            end
            ST_STREAM: begin
               if (pop && m_axis_tlast) begin
                  state          <= ST_DONE;
                  forwarder_done <= 1'b1;
               end
            end
            // One cycle of done, then one cycle where ready is ignored while memory drops it
            ST_DONE: state <= ST_HOLD;
            ST_HOLD: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axistream_forwarder.sv
// Directed bench for axistream_forwarder with a 1-cycle-latency packet memory model and a stream monitor.
// Latency: n/a.
// Backpressure: tready driven per cycle from a per-test pattern.
module tb_axistream_forwarder;

   localparam int AW = 9;
   localparam int DW = 64;
   localparam int PW = AW + 1;

   logic          clk;
   logic          rst;
   logic          ready_for_forwarder;
   logic [PW-1:0] len_to_forwarder;
   logic [AW-1:0] forwarder_rd_addr;
   logic          forwarder_rd_en;
   logic [DW-1:0] forwarder_rd_data;
   logic          forwarder_done;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready;

   axistream_forwarder #(
      .SNOOP_FWD_ADDR_WIDTH (AW),
      .DATA_WIDTH           (DW)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .ready_for_forwarder (ready_for_forwarder),
      .len_to_forwarder    (len_to_forwarder),
      .forwarder_rd_addr   (forwarder_rd_addr),
      .forwarder_rd_en     (forwarder_rd_en),
      .forwarder_rd_data   (forwarder_rd_data),
      .forwarder_done      (forwarder_done),
      .m_axis_tdata        (m_axis_tdata),
      .m_axis_tvalid       (m_axis_tvalid),
      .m_axis_tlast        (m_axis_tlast),
      .m_axis_tready       (m_axis_tready)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DW-1:0] mem [0:511];

   logic [DW-1:0] beat_q [$];
   bit            last_q [$];
   int            addr_q [$];
   int first_beat_cyc, last_beat_cyc, first_rd_cyc;
   int last_done_cyc = -100;
   int done_cnt = 0;
   int stall_viol, rd_gap, rd_total, pop_total, max_out;
   logic          hold_prev;
   logic [DW-1:0] prev_dat;
   logic          prev_last;
   int pkt_start;
   int mode;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Packet memory: data valid one cycle after rd_en, garbage otherwise
   always @(posedge clk)
      forwarder_rd_data <= forwarder_rd_en ? mem[forwarder_rd_addr] : 64'hBAD0_BAD0_BAD0_BAD0;

   // Stream and read-port monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (forwarder_done) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (forwarder_rd_en) begin
            addr_q.push_back(int'(forwarder_rd_addr));
            rd_total++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (cyc <= last_done_cyc + 2) rd_gap++;
         end
         if (hold_prev && (!m_axis_tvalid || m_axis_tdata !== prev_dat || m_axis_tlast !== prev_last))
            stall_viol++;
         if (m_axis_tvalid && m_axis_tready) begin
            beat_q.push_back(m_axis_tdata);
            last_q.push_back(m_axis_tlast);
            pop_total++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
         end
         if (rd_total - pop_total > max_out) max_out = rd_total - pop_total;
         hold_prev = m_axis_tvalid && !m_axis_tready;
         prev_dat  = m_axis_tdata;
         prev_last = m_axis_tlast;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_tready();
      int rel;
      rel = cyc - pkt_start;
      case (mode)
         1:       m_axis_tready = (rel % 2 == 0);
         2:       m_axis_tready = !(rel >= 5 && rel < 10);
         default: m_axis_tready = 1'b1;
      endcase
   endtask

   // Called just after a rising edge; the DUT samples ready at the next edge
   task automatic start_pkt(input int len, input logic [63:0] base);
      for (int i = 0; i < 512; i++) mem[i] = base + 64'(i);
      beat_q.delete();
      last_q.delete();
      addr_q.delete();
      first_beat_cyc = -1;
      last_beat_cyc  = -1;
      first_rd_cyc   = -1;
      stall_viol = 0;
      rd_gap     = 0;
      rd_total   = 0;
      pop_total  = 0;
      max_out    = 0;
      hold_prev  = 1'b0;
      pkt_start  = cyc;
      ready_for_forwarder = 1'b1;
      len_to_forwarder    = PW'(len);
      drive_tready();
   endtask

   task automatic wait_done(input int budget, input int done_before, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(posedge clk);
         #1;
         drive_tready();
         if (done_cnt > done_before) ok = 1'b1;
      end
   endtask

   task automatic check_pkt(input string tag, input int len, input logic [63:0] base, input int done_before);
      int nbad, nlast, lastidx, abad;
      nbad = 0; nlast = 0; lastidx = -1; abad = 0;
      for (int i = 0; i < beat_q.size(); i++) begin
         if (beat_q[i] !== base + 64'(i)) nbad++;
         if (last_q[i]) begin
            nlast++;
            if (lastidx < 0) lastidx = i;
         end
      end
      for (int i = 0; i < addr_q.size(); i++)
         if (addr_q[i] != (i % 512)) abad++;
      check({tag, "_beats"}, beat_q.size(), len);
      check({tag, "_data"}, nbad, 0);
      check({tag, "_tlast_cnt"}, nlast, (len > 0) ? 1 : 0);
      check({tag, "_reads"}, rd_total, len);
      check({tag, "_addr"}, abad, 0);
      check({tag, "_done_cnt"}, done_cnt - done_before, 1);
      check({tag, "_credit_le2"}, (max_out <= 2), 1);
      check({tag, "_stall_stable"}, stall_viol, 0);
      if (len > 0) begin
         check({tag, "_tlast_idx"}, lastidx, len - 1);
         check({tag, "_done_lat"}, last_done_cyc - last_beat_cyc, 1);
      end
   endtask

   task automatic run_pkt(input string tag, input int len, input logic [63:0] base, input int md);
      int dc0;
      bit ok;
      mode = md;
      dc0  = done_cnt;
      start_pkt(len, base);
      wait_done(4 * len + 40, dc0, ok);
      check({tag, "_finished"}, ok, 1);
      ready_for_forwarder = 1'b0;
      mode = 0;
      m_axis_tready = 1'b1;
      check_pkt(tag, len, base, dc0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int dc0, dc1, d1;
      bit ok;
      rst = 1'b1;
      ready_for_forwarder = 1'b0;
      len_to_forwarder = '0;
      m_axis_tready = 1'b1;
      mode = 0;
      pkt_start = 0;
      repeat (3) @(posedge clk);
      #1;
      // Reset values
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_rd_en", forwarder_rd_en, 0);
      check("rst_rd_addr", forwarder_rd_addr, 0);
      check("rst_done", forwarder_done, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Basic: 4 words, tready high, exact timing
      run_pkt("basic", 4, 64'hA0, 0);
      check("basic_first_rd", first_rd_cyc - pkt_start, 1);
      check("basic_first_beat", first_beat_cyc - pkt_start, 3);
      check("basic_no_bubble", last_beat_cyc - first_beat_cyc, 3);
      check("basic_done_at", last_done_cyc - pkt_start, 7);

      // Backpressure: alternating tready, then a 5-cycle low stretch
      run_pkt("toggle", 8, 64'h5500, 1);
      run_pkt("stretch", 8, 64'h7700, 2);

      // Zero and one word
      run_pkt("len0", 0, 64'h0, 0);
      check("len0_done_at", last_done_cyc - pkt_start, 1);
      run_pkt("len1", 1, 64'hC0DE, 0);
      check("len1_first_beat", first_beat_cyc - pkt_start, 3);

      // Maximum length: address wraps only after the last word
      run_pkt("max", 512, 64'h1000_0000_0000_0000, 0);
      check("max_last_addr", addr_q[addr_q.size() - 1], 511);

      // Back-to-back: ready stays high across done with a new length
      mode = 0;
      dc0 = done_cnt;
      start_pkt(3, 64'hB100);
      wait_done(60, dc0, ok);
      check("b2b_a_finished", ok, 1);
      check_pkt("b2b_a", 3, 64'hB100, dc0);
      d1  = last_done_cyc;
      dc1 = done_cnt;
      start_pkt(5, 64'hB200);
      wait_done(60, dc1, ok);
      check("b2b_b_finished", ok, 1);
      ready_for_forwarder = 1'b0;
      check("b2b_gap_ge3", (first_rd_cyc - d1 >= 3), 1);
      check("b2b_no_rd_in_done_hold", rd_gap, 0);
      check_pkt("b2b_b", 5, 64'hB200, dc1);
      repeat (2) @(posedge clk);
      #1;

      // Reset during beat 2 of 8
      mode = 0;
      dc0 = done_cnt;
      start_pkt(8, 64'hE000);
      for (int n = 0; n < 40 && beat_q.size() < 2; n++) begin
         @(negedge clk);
         #2;
      end
      check("mid_two_beats_seen", beat_q.size(), 2);
      rst = 1'b1;
      #1;
      check("mid_rst_tvalid", m_axis_tvalid, 0);
      check("mid_rst_tlast", m_axis_tlast, 0);
      check("mid_rst_tdata", m_axis_tdata, 0);
      check("mid_rst_rd_en", forwarder_rd_en, 0);
      check("mid_rst_rd_addr", forwarder_rd_addr, 0);
      check("mid_rst_done", forwarder_done, 0);
      ready_for_forwarder = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_no_done", done_cnt - dc0, 0);
      check("mid_idle_tvalid", m_axis_tvalid, 0);
      run_pkt("replay", 8, 64'hE000, 0);
      check("replay_first_addr", addr_q[0], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
